// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared types, constants and helpers for the multi-channel clock divider
package clock_divider_pkg;

    localparam int DEF_WIDTH = 16;

    typedef logic [DEF_WIDTH-1:0] div_t;

    // Level every divided clock takes on reset and on a phase realignment.
    localparam logic CLK_RESET_LVL = 1'b1;

    // Channel-select width; a single-channel build still gets a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one divider channel: counter, divisor, toggle flop (CLOCK_DIVIDER_GLITCHFREE_EN adds a pending divisor)
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sync,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div;
    logic             enabled;
    logic             rollover;

`ifdef CLOCK_DIVIDER_GLITCHFREE_EN
    logic [WIDTH-1:0] pend;
    logic             pend_valid;
`endif

    // A zero divisor parks the channel; div is never zero when div-1 is used.
    always_comb begin
        enabled  = (div != '0);
        rollover = enabled && (cnt == div - ONE);
    end

    // Counter, toggle flop and divisor update; a load never cancels a same-cycle rollover.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt    <= '0;
            div    <= DIV_RST;
            o_clk  <= CLK_RESET_LVL;
            o_tick <= 1'b0;
`ifdef CLOCK_DIVIDER_GLITCHFREE_EN
            pend       <= '0;
            pend_valid <= 1'b0;
`endif
        end else if (i_sync) begin
            cnt    <= '0;
            o_clk  <= CLK_RESET_LVL;
            o_tick <= 1'b0;
`ifdef CLOCK_DIVIDER_GLITCHFREE_EN
            if (pend_valid) begin
                div <= pend;
            end
            pend_valid <= 1'b0;
`endif
        end else begin
            o_tick <= rollover;
            if (rollover) begin
                cnt   <= '0;
                o_clk <= ~o_clk;
`ifdef CLOCK_DIVIDER_GLITCHFREE_EN
                if (pend_valid) begin
                    div        <= pend;
                    pend_valid <= 1'b0;
                end
`endif
            end else if (enabled) begin
                cnt <= cnt + ONE;
            end else begin
                cnt <= '0;
            end

            if (i_load) begin
`ifdef CLOCK_DIVIDER_GLITCHFREE_EN
                // Apply now only where no half-period is in flight to be shortened.
                if (!enabled || rollover) begin
                    div        <= i_divisor;
                    cnt        <= '0;
                    pend_valid <= 1'b0;
                end else begin
                    pend       <= i_divisor;
                    pend_valid <= 1'b1;
                end
`else
                div <= i_divisor;
                cnt <= '0;
`endif
            end
        end
    end

endmodule

// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - N-channel programmable clock divider top (optional CLOCK_DIVIDER_GLITCHFREE_EN)
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int N_CHANNELS  = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_sync,
    input  logic                              i_load,
    input  logic [ch_width(N_CHANNELS)-1:0]   i_channel,
    input  logic [WIDTH-1:0]                  i_divisor,
    output logic [N_CHANNELS-1:0]             o_clk,
    output logic [N_CHANNELS-1:0]             o_tick,
    output logic                              o_load_err
);

    localparam int               CH_W   = ch_width(N_CHANNELS);
    localparam logic [CH_W:0]    N_CH_L = (CH_W+1)'(N_CHANNELS);

    logic ch_valid;

    // The select may encode more channels than exist when N_CHANNELS is not a power of two.
    always_comb begin
        ch_valid = ({1'b0, i_channel} < N_CH_L);
    end

    // A load to a missing channel changes nothing but is flagged for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_load_err <= 1'b0;
        end else begin
            o_load_err <= i_load && !ch_valid;
        end
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(c);

        logic load_c;

        // Route the load only to the addressed channel.
        always_comb begin
            load_c = i_load && ch_valid && (i_channel == IDX);
        end

        clock_divider_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_sync    (i_sync),
            .i_load    (load_c),
            .i_divisor (i_divisor),
            .o_clk     (o_clk[c]),
            .o_tick    (o_tick[c])
        );
    end

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - directed self-checking bench for clock_divider
module tb_clock_divider;

    logic        clk;
    logic        reset;

    logic        a_sync, a_load;
    logic [1:0]  a_channel;
    logic [15:0] a_divisor;
    logic [3:0]  a_clk, a_tick;
    logic        a_err;

    logic        b_sync, b_load;
    logic [1:0]  b_channel;
    logic [15:0] b_divisor;
    logic [2:0]  b_clk, b_tick;
    logic        b_err;

    int n_cmp = 0;
    int n_err = 0;
    int divs[4];

    logic [8:0] tbl_clk;
    logic [8:0] tbl_tick;

    clock_divider #(.N_CHANNELS(4), .WIDTH(16), .DEFAULT_DIV(1)) u_dut_a (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_sync     (a_sync),
        .i_load     (a_load),
        .i_channel  (a_channel),
        .i_divisor  (a_divisor),
        .o_clk      (a_clk),
        .o_tick     (a_tick),
        .o_load_err (a_err)
    );

    clock_divider #(.N_CHANNELS(3), .WIDTH(16), .DEFAULT_DIV(1)) u_dut_b (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_sync     (b_sync),
        .i_load     (b_load),
        .i_channel  (b_channel),
        .i_divisor  (b_divisor),
        .o_clk      (b_clk),
        .o_tick     (b_tick),
        .o_load_err (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle k after a phase realignment: level holds for d cycles, tick every d cycles.
    function automatic logic exp_clk1(input int k, input int d);
        return ((k / d) % 2) == 0;
    endfunction

    function automatic logic exp_tick1(input int k, input int d);
        return (k > 0) && ((k % d) == 0);
    endfunction

    task automatic check_all(input string tag, input int k);
        logic [3:0] ec;
        logic [3:0] et;
        for (int c = 0; c < 4; c++) begin
            ec[c] = exp_clk1(k, divs[c]);
            et[c] = exp_tick1(k, divs[c]);
        end
        check($sformatf("%s clk k=%0d", tag, k), 32'(a_clk), 32'(ec));
        check($sformatf("%s tick k=%0d", tag, k), 32'(a_tick), 32'(et));
    endtask

    task automatic load_a(input int ch, input int d);
        a_load    = 1'b1;
        a_channel = 2'(ch);
        a_divisor = 16'(d);
    endtask

    initial begin
        reset = 1'b1;
        a_sync = 1'b0; a_load = 1'b0; a_channel = '0; a_divisor = '0;
        b_sync = 1'b0; b_load = 1'b0; b_channel = '0; b_divisor = '0;

        // Reset held two cycles, then every channel divides by one
        cyc(); cyc();
        check("reset err", 32'(a_err), 32'd0);
        check("reset b clk", 32'(b_clk), 32'h7);
        divs = '{1, 1, 1, 1};
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_all("reset", k);
            cyc();
        end

        // Divide channel 1 by 3, realign, observe all channels
        load_a(1, 3);
        cyc();
        a_load = 1'b0;
        a_sync = 1'b1;
        cyc();
        a_sync = 1'b0;
        divs = '{1, 3, 1, 1};
        for (int k = 0; k <= 10; k++) begin
            check_all("divide", k);
            if (k < 10) cyc();
        end

        // Disable channel 2 so it parks low (load edge is also its last rollover)
        load_a(2, 0);
        cyc();
        a_load = 1'b0;
        check("disable clk2 park", 32'(a_clk[2]), 32'd0);
        for (int i = 0; i < 50; i++) begin
            cyc();
            check($sformatf("disable clk2 i=%0d", i), 32'(a_clk[2]), 32'd0);
            check($sformatf("disable tick2 i=%0d", i), 32'(a_tick[2]), 32'd0);
        end

        // Re-enable channel 2 with divisor 2
        load_a(2, 2);
        cyc();
        a_load = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check($sformatf("reload clk2 j=%0d", j), 32'(a_clk[2]), 32'(((j / 2) % 2) == 1));
            check($sformatf("reload tick2 j=%0d", j), 32'(a_tick[2]), 32'((j > 0) && (j % 2 == 0)));
            cyc();
        end

        // Divisors 2,3,5,7, free-run, then realign with a colliding load that must be dropped
        load_a(0, 2); cyc();
        load_a(1, 3); cyc();
        load_a(2, 5); cyc();
        load_a(3, 7); cyc();
        a_load = 1'b0;
        repeat (40) cyc();
        a_sync = 1'b1;
        load_a(0, 9);
        cyc();
        a_sync = 1'b0;
        a_load = 1'b0;
        divs = '{2, 3, 5, 7};
        for (int k = 0; k < 16; k++) begin
            check_all("sync", k);
            cyc();
        end

        // Mid-half-period divisor change on channel 0: 8 -> 2 at cnt=3
        load_a(0, 8);
        cyc();
        a_load = 1'b0;
        a_sync = 1'b1;
        cyc();
        a_sync = 1'b0;
        check("change clk0 k=0", 32'(a_clk[0]), 32'd1);
        cyc(); cyc(); cyc();
        load_a(0, 2);
        cyc();
        a_load = 1'b0;
`ifdef CLOCK_DIVIDER_GLITCHFREE_EN
        tbl_clk  = 9'b011001111;
        tbl_tick = 9'b101010000;
`else
        tbl_clk  = 9'b100110011;
        tbl_tick = 9'b101010100;
`endif
        for (int i = 0; i < 9; i++) begin
            check($sformatf("change clk0 k=%0d", i + 4), 32'(a_clk[0]), 32'(tbl_clk[i]));
            check($sformatf("change tick0 k=%0d", i + 4), 32'(a_tick[0]), 32'(tbl_tick[i]));
            cyc();
        end

        // Bad channel on the three-channel instance
        b_sync = 1'b1;
        cyc();
        b_sync = 1'b0;
        b_load = 1'b1;
        b_channel = 2'd3;
        b_divisor = 16'd5;
        check("badch pre err", 32'(b_err), 32'd0);
        check("badch pre clk", 32'(b_clk), 32'h7);
        check("badch pre tick", 32'(b_tick), 32'h0);
        cyc();
        b_load = 1'b0;
        check("badch err pulse", 32'(b_err), 32'd1);
        check("badch clk1", 32'(b_clk), 32'h0);
        check("badch tick1", 32'(b_tick), 32'h7);
        cyc();
        check("badch err clear", 32'(b_err), 32'd0);
        check("badch clk2", 32'(b_clk), 32'h7);
        check("badch tick2", 32'(b_tick), 32'h7);
        cyc();
        check("badch err stay", 32'(b_err), 32'd0);
        check("badch clk3", 32'(b_clk), 32'h0);
        check("badch tick3", 32'(b_tick), 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Parametrised successor to the rollover-driven toggle clock.
- Generates N_CHANNELS divided clocks, all from the single system clock i_clk.
- Each channel has its own counter and a run-time programmable divisor. On each counter rollover the channel toggles its clock and emits a one-cycle tick.
- Sits between the system clock and slow peripherals (LED blinkers, UART baud, seven-segment multiplexing).

Parameters:
- N_CHANNELS, 4: number of independent divider channels (1..16).
- WIDTH, 16: width of counters and divisors.
- DEFAULT_DIV, 1: divisor loaded into every channel on reset (0..2^WIDTH-1).

Ports:
- i_clk, input, 1: system clock; all logic on rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_sync, input, 1: pulse; realigns the phase of all channels.
- i_load, input, 1: pulse; writes i_divisor to channel i_channel.
- i_channel, input, $clog2(N_CHANNELS) (min 1): target channel of a load.
- i_divisor, input, WIDTH: new divisor value.
- o_clk, output, N_CHANNELS: divided clocks.
- o_tick, output, N_CHANNELS: one-cycle rollover pulses.
- o_load_err, output, 1: one-cycle pulse when a load names a nonexistent channel.

Behaviour:
- Reset, synchronous and active-high, sampled on the i_clk edge:
  - cnt[c]=0, div[c]=DEFAULT_DIV;
  - o_clk = all ones; o_tick = 0; o_load_err = 0;
  - any pending divisor is cleared.
- Priority per channel: i_reset > i_sync > i_load > counting.
- Counting, when div[c] != 0:
  - If cnt[c] == div[c]-1: cnt[c] <= 0, o_clk[c] toggles, o_tick[c] = 1 for that one cycle (registered).
  - Otherwise cnt[c] increments and o_tick[c] = 0.
  - Output period is 2*div i_clk cycles with 50 % duty; tick period is div cycles.
  - div=1: o_clk toggles every cycle; o_tick is held high.
- Disabled channel, div[c]==0: cnt holds at 0, o_clk[c] holds its value, o_tick[c]=0.
- i_sync:
  - all cnt <= 0, all o_clk <= 1, o_tick <= 0;
  - divisors are kept and pending divisors are applied;
  - a load in the same cycle is dropped.
- i_load with i_channel >= N_CHANNELS: no state change; o_load_err=1 in the next cycle.
- Apply-load, default build:
  - div[ch] <= i_divisor and cnt[ch] <= 0; o_clk[ch] is unchanged.
  - If that channel would roll over in the same cycle, the toggle and tick still happen before the new divisor takes effect.
- Counters are unsigned WIDTH bits. The div-1 comparison never underflows because div==0 is handled by the disabled case.
- Reset mid-operation loses all programmed divisors.

Optional Feature:
- Macro: CLOCK_DIVIDER_GLITCHFREE_EN.
- Defined:
  - A load stores into pend[ch] and sets pend_valid[ch].
  - The new divisor is applied at that channel's next rollover, so the current half-period completes unshortened.
  - It is applied immediately if the channel is disabled (div==0).
  - A second load before application overwrites pend.
- Undefined: immediate apply-load as in Behaviour; no pending registers are synthesised.

Decomposition:
- Package clock_divider_pkg holds:
  - localparam CH_W = (N_CHANNELS>1) ? $clog2(N_CHANNELS) : 1;
  - typedef div_t = logic [WIDTH-1:0];
  - the reset clock level constant CLK_RESET_LVL = 1'b1.
- Sub-module clock_divider_channel:
  - one counter, divisor and toggle flop, plus the optional pending register;
  - ports: i_clk, i_reset, i_sync, i_load, i_divisor, o_clk, o_tick.
- The top level generates N_CHANNELS instances and decodes i_channel / o_load_err.

Test Plan:
- Reset: N_CHANNELS=4, DEFAULT_DIV=1, hold reset 2 cycles, release -> o_clk=4'b1111 immediately; every channel toggles each cycle thereafter; o_tick=4'b1111 continuously.
- Divide: load ch1 with 3 -> o_clk[1] stays high 3 cycles, low 3, high 3; o_tick[1] pulses every 3rd cycle; other channels unaffected.
- Disable: load ch2 with 0 while o_clk[2]=0 -> o_clk[2] holds 0 for 50 cycles; o_tick[2] stays 0; reload with 2 -> toggling resumes after 2 cycles.
- Sync: channels at divisors 2,3,5,7 run 40 cycles, then pulse i_sync -> next cycle o_clk=4'b1111, all cnt=0; first toggles after 2,3,5,7 cycles respectively.
- Bad channel, with N_CHANNELS=3: load i_channel=3 -> o_load_err=1 for exactly one cycle; all divisors unchanged.
- Glitch-free: with CLOCK_DIVIDER_GLITCHFREE_EN, ch0 div=8, load 2 at cnt=3 -> the current half-period still lasts 8 cycles, then 2-cycle half-periods. Without the macro: cnt clears, the next toggle occurs 2 cycles after the load.
